sblock_cfg_loader: RTL

Configuration writer for the switch-block array. It receives a serial configuration bitstream over a valid/ready handshake and assembles 18-bit frames (9 horizontal dot-control bits, then 9 vertical). It presents each frame on a shared `bits` bus and pulses the matching per-block `wr_en` so every switch block captures its frame on the next rising edge. It sits between the off-chip/JTAG-side bit source and the switch-block grid and owns the whole load sequence.

---
 rtl/sblock_cfg_pkg.sv | 24 ++
 rtl/sblock_cfg_loader_if.sv | 12 +
 rtl/sblock_frame_shifter.sv | 37 +++
 rtl/sblock_cfg_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sblock_cfg_pkg.sv
// Shared constants, FSM state type and frame field helpers for the switch-block
// configuration loader.
package sblock_cfg_pkg;

  localparam int unsigned SB_FRAME_W = 18;
  localparam int unsigned SB_DOTS    = 9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } cfg_state_e;

  // Horizontal dot-control bits occupy the upper half of a frame.
  function automatic logic [SB_DOTS-1:0] frame_h(input logic [SB_FRAME_W-1:0] frame);
    return frame[SB_FRAME_W-1:SB_DOTS];
  endfunction

  function automatic logic [SB_DOTS-1:0] frame_v(input logic [SB_FRAME_W-1:0] frame);
    return frame[SB_DOTS-1:0];
  endfunction

endpackage

// File: rtl/sblock_cfg_loader_if.sv
// Serial configuration bitstream handshake between the bit source (master)
// and the loader (slave).
interface sblock_cfg_loader_if;

  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (output cfg_valid, output cfg_bit, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_bit, output cfg_ready);

endinterface

// File: rtl/sblock_frame_shifter.sv
// MSB-first frame assembler: shift register plus accept counter that flags the
// cycle in which the final bit of a frame is taken.
module sblock_frame_shifter import sblock_cfg_pkg::*; #(
  parameter int unsigned FRAME_W = SB_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               accept_i,
  input  logic               bit_i,
  output logic [FRAME_W-1:0] frame_next_o,
  output logic               frame_full_o
);

  localparam int unsigned CntW = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] shreg_q;
  logic [CntW-1:0]    count_q;

  // Frame as it will look once the current bit is shifted in; lets the owner
  // capture a completed frame on the same edge that accepts its last bit.
  assign frame_next_o = {shreg_q[FRAME_W-2:0], bit_i};
  assign frame_full_o = accept_i && (count_q == CntW'(FRAME_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (accept_i) begin
      shreg_q <= frame_next_o;
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/sblock_cfg_loader.sv
// Switch-block configuration writer: assembles serial frames and strobes them
// into the blocks in ascending index order over a shared bits bus.
module sblock_cfg_loader import sblock_cfg_pkg::*; #(
  parameter int unsigned NUM_SB  = 4,
  parameter int unsigned FRAME_W = SB_FRAME_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  sblock_cfg_loader_if.slave  cfg,
  output logic [FRAME_W-1:0]  bits_o,
  output logic [NUM_SB-1:0]   wr_en_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned IdxW = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;

  cfg_state_e         state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               clear;
  logic               accept;
  logic               frame_full;
  logic [FRAME_W-1:0] frame_next;

  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_SB-1:0]  wr_en_q, wr_en_d;
  logic [FRAME_W-1:0] bits_q;

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;

  sblock_frame_shifter #(
    .FRAME_W (FRAME_W)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .accept_i     (accept),
    .bit_i        (cfg.cfg_bit),
    .frame_next_o (frame_next),
    .frame_full_o (frame_full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          idx_d   = '0;
          clear   = 1'b1;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (frame_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (idx_q == IdxW'(NUM_SB - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
          idx_d   = idx_q + 1'b1;
          clear   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_en_d = '0;
    for (int unsigned k = 0; k < NUM_SB; k++) begin
      wr_en_d[k] = (state_d == WRITE) && (idx_d == IdxW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= '0;
      bits_q  <= '0;
    end else begin
      ready_q <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      wr_en_q <= wr_en_d;
      if (state_q == SHIFT && state_d == WRITE) begin
        bits_q <= frame_next;
      end
    end
  end

  assign bits_o  = bits_q;
  assign wr_en_o = wr_en_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
